// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller: owns the PC, handshakes with instruction memory and feeds IF/ID.
// Optional macro FETCH_ALIGN_CHECK_EN adds fetch_err and halts on odd redirect targets.
module fetch_ctrl #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] NOP_INSTR = 16'h0800
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_in,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  input  logic        halt_in,
  output logic        mem_rd,
  output logic [15:0] mem_addr,
  input  logic        mem_done,
  input  logic [15:0] mem_data,
  output logic        ifid_write,
  output logic        ifid_flush,
  output logic [15:0] ifid_pc,
  output logic [15:0] ifid_instr
`ifdef FETCH_ALIGN_CHECK_EN
  ,
  output logic        fetch_err
`endif
);

  typedef enum logic [1:0] {FETCH, HOLD, DRAIN, HALTED} state_t;

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] buf_q, buf_d;
  logic [15:0] bufpc_q, bufpc_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] pc_inc;
  logic [15:0] target;
  logic        bad_target;
  logic        redir_act;

  assign pc_inc    = pc_q + 16'd2;
  assign redir_act = redirect && (state_q != HALTED);

`ifdef FETCH_ALIGN_CHECK_EN
  logic err_q, err_d;
  assign target     = redirect_pc;
  assign bad_target = redirect_pc[0];
  assign fetch_err  = err_q;
`else
  assign target     = redirect_pc & 16'hFFFE;
  assign bad_target = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    buf_d      = buf_q;
    bufpc_d    = bufpc_q;
    addr_d     = addr_q;
`ifdef FETCH_ALIGN_CHECK_EN
    err_d      = err_q;
`endif
    mem_rd     = 1'b0;
    mem_addr   = pc_q;
    ifid_write = 1'b0;
    ifid_flush = 1'b0;
    ifid_pc    = 16'h0000;
    ifid_instr = NOP_INSTR;

    case (state_q)
      FETCH: begin
        mem_rd     = 1'b1;
        addr_d     = pc_q;
        ifid_pc    = pc_inc;
        ifid_instr = mem_data;
        if (mem_done) begin
          pc_d = pc_inc;
          if (!stall_in) begin
            ifid_write = 1'b1;
          end else begin
            buf_d   = mem_data;
            bufpc_d = pc_inc;
            state_d = HOLD;
          end
        end
        if (halt_in) state_d = HALTED;
      end
      HOLD: begin
        ifid_pc    = bufpc_q;
        ifid_instr = buf_q;
        if (!stall_in) begin
          ifid_write = 1'b1;
          state_d    = FETCH;
        end
        if (halt_in) state_d = HALTED;
      end
      DRAIN: begin
        // The old request is still in flight; keep presenting its address until it completes.
        mem_rd   = 1'b1;
        mem_addr = addr_q;
        if (mem_done) state_d = FETCH;
        if (halt_in) state_d = HALTED;
      end
      default: begin
      end
    endcase

    // A redirect squashes whatever the state logic decided above.
    if (redir_act) begin
      ifid_flush = 1'b1;
      ifid_write = 1'b0;
      ifid_pc    = 16'h0000;
      ifid_instr = NOP_INSTR;
      pc_d       = pc_q;
      if (bad_target) begin
`ifdef FETCH_ALIGN_CHECK_EN
        err_d = 1'b1;
`endif
        state_d = HALTED;
      end else begin
        pc_d    = target;
        state_d = (state_q != HOLD && !mem_done) ? DRAIN : FETCH;
      end
    end

    if (rst) begin
      mem_rd     = 1'b0;
      mem_addr   = RESET_PC;
      ifid_write = 1'b0;
      ifid_flush = 1'b0;
      ifid_pc    = 16'h0000;
      ifid_instr = NOP_INSTR;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      buf_q   <= 16'h0000;
      bufpc_q <= 16'h0000;
      addr_q  <= RESET_PC;
`ifdef FETCH_ALIGN_CHECK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      buf_q   <= buf_d;
      bufpc_q <= bufpc_d;
      addr_q  <= addr_d;
`ifdef FETCH_ALIGN_CHECK_EN
      err_q   <= err_d;
`endif
    end
  end

endmodule
